// File: rtl/l2_mem_block_engine.sv
// l2_mem_block_engine: memory-side block transfer engine for the L2 controller.
// Turns one block request (optional victim writeback, then a line fill) into
// sequential single-word accesses on main_memory's word port and assembles
// the returned words into a full cache line.
module l2_mem_block_engine #(
  parameter int n      = 32,
  parameter int WORDS  = 4,
  parameter int ADDR_W = 15,
  parameter int BLK_W  = ADDR_W - $clog2(WORDS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fill_req,
  input  logic                 wb_req,
  input  logic [BLK_W-1:0]     fill_addr,
  input  logic [BLK_W-1:0]     wb_addr,
  input  logic [n*WORDS-1:0]   wb_block,
  output logic                 busy,
  output logic                 done,
  output logic [n*WORDS-1:0]   fill_block,
  output logic [ADDR_W-1:0]    L2_word_address,
  output logic                 L2_read_request,
  output logic                 L2_write_request,
  output logic [n-1:0]         L2_wdata,
  input  logic [n-1:0]         L2_rdata
);

  localparam int IDX_W = $clog2(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    WB,
    RD,
    RLAST,
    DONE
  } state_t;

  state_t               state;
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     idx_prev;
  logic [BLK_W-1:0]     fill_addr_q;
  logic [BLK_W-1:0]     wb_addr_q;
  // Holds words 0..WORDS-2; the last word is taken straight from L2_rdata
  // when the line is committed to fill_block.
  logic [n*(WORDS-1)-1:0] line_buf;

  assign idx_prev = idx - IDX_W'(1);

  // Sequencer: walks WB then RD word by word, collects read data one cycle late.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      fill_addr_q <= '0;
      wb_addr_q   <= '0;
      line_buf    <= '0;
      fill_block  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fill_req) begin
            fill_addr_q <= fill_addr;
            wb_addr_q   <= wb_addr;
            idx         <= '0;
            state       <= wb_req ? WB : RD;
          end
        end
        WB: begin
          if (idx == LAST_IDX) begin
            idx   <= '0;
            state <= RD;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        RD: begin
          if (idx != '0) begin
            line_buf[idx_prev*n +: n] <= L2_rdata;
          end
          idx <= idx + IDX_W'(1);
          if (idx == LAST_IDX) begin
            state <= RLAST;
          end
        end
        RLAST: begin
          fill_block <= {L2_rdata, line_buf};
          state      <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Moore decode of the memory-side port and status flags from state and idx.
  always_comb begin
    L2_read_request  = 1'b0;
    L2_write_request = 1'b0;
    L2_word_address  = '0;
    L2_wdata         = '0;
    case (state)
      WB: begin
        L2_write_request = 1'b1;
        L2_word_address  = {wb_addr_q, idx};
        L2_wdata         = wb_block[idx*n +: n];
      end
      RD: begin
        L2_read_request = 1'b1;
        L2_word_address = {fill_addr_q, idx};
      end
      default: begin
        L2_read_request  = 1'b0;
        L2_write_request = 1'b0;
      end
    endcase
    busy = (state != IDLE);
    done = (state == DONE);
  end

endmodule

// File: tb/tb_l2_mem_block_engine.sv
// tb_l2_mem_block_engine: scoreboard bench for the L2 memory block engine,
// with a behavioural word memory behind the L2_* port.
module tb_l2_mem_block_engine;

  localparam int N      = 32;
  localparam int WORDS  = 4;
  localparam int ADDR_W = 15;
  localparam int BLK_W  = 13;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 fill_req;
  logic                 wb_req;
  logic [BLK_W-1:0]     fill_addr;
  logic [BLK_W-1:0]     wb_addr;
  logic [N*WORDS-1:0]   wb_block;
  logic                 busy;
  logic                 done;
  logic [N*WORDS-1:0]   fill_block;
  logic [ADDR_W-1:0]    L2_word_address;
  logic                 L2_read_request;
  logic                 L2_write_request;
  logic [N-1:0]         L2_wdata;
  logic [N-1:0]         L2_rdata = '0;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [N-1:0]      wdata;
  } access_t;

  access_t            acc_q[$];
  logic [N*WORDS-1:0] fill_q[$];
  access_t            exp_acc;
  logic [N*WORDS-1:0] exp_line;

  int checks     = 0;
  int errors     = 0;
  int done_count = 0;
  bit mon_en     = 1'b0;

  logic [N-1:0] mem [0:(1<<ADDR_W)-1];

  always #5 clk = ~clk;

  l2_mem_block_engine dut (
    .clk              (clk),
    .reset            (reset),
    .fill_req         (fill_req),
    .wb_req           (wb_req),
    .fill_addr        (fill_addr),
    .wb_addr          (wb_addr),
    .wb_block         (wb_block),
    .busy             (busy),
    .done             (done),
    .fill_block       (fill_block),
    .L2_word_address  (L2_word_address),
    .L2_read_request  (L2_read_request),
    .L2_write_request (L2_write_request),
    .L2_wdata         (L2_wdata),
    .L2_rdata         (L2_rdata)
  );

  // Word memory: write commits at the edge, read data appears the next cycle.
  always @(posedge clk) begin
    if (L2_write_request) mem[L2_word_address] = L2_wdata;
    if (L2_read_request) L2_rdata <= mem[L2_word_address];
  end

  // Monitor: compare every memory access and every done pulse with the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      if (L2_read_request || L2_write_request) begin
        checks++;
        if (L2_read_request && L2_write_request) begin
          errors++;
          $display("[TB] FAIL both_requests: read=%0b write=%0b required not both high", L2_read_request, L2_write_request);
        end
        checks++;
        if (acc_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_access: addr=%h write=%0b, none required", L2_word_address, L2_write_request);
        end else begin
          exp_acc = acc_q.pop_front();
          if (L2_write_request !== exp_acc.we || L2_read_request !== !exp_acc.we ||
              L2_word_address !== exp_acc.addr || (exp_acc.we && L2_wdata !== exp_acc.wdata)) begin
            errors++;
            $display("[TB] FAIL access: got we=%0b addr=%h wdata=%h required we=%0b addr=%h wdata=%h",
                     L2_write_request, L2_word_address, L2_wdata, exp_acc.we, exp_acc.addr, exp_acc.wdata);
          end
        end
      end
      if (done) begin
        done_count++;
        checks++;
        if (fill_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_done: fill_block=%h, no done required", fill_block);
        end else begin
          exp_line = fill_q.pop_front();
          if (fill_block !== exp_line) begin
            errors++;
            $display("[TB] FAIL fill_block: got %h required %h", fill_block, exp_line);
          end
        end
      end
    end
  end

  // Push expected accesses/line, then present the request across one accepting edge.
  task automatic start_fill(input logic [BLK_W-1:0] fa, input bit wr, input logic [BLK_W-1:0] wa,
                            input logic [N*WORDS-1:0] blk, input bit expect_fill);
    logic [N*WORDS-1:0] line;
    access_t a;
    for (int k = 0; k < WORDS; k++) begin
      if (wr) begin
        a.we = 1'b1; a.addr = {wa, k[1:0]}; a.wdata = blk[k*N +: N];
        acc_q.push_back(a);
      end
    end
    for (int k = 0; k < WORDS; k++) begin
      a.we = 1'b0; a.addr = {fa, k[1:0]}; a.wdata = '0;
      acc_q.push_back(a);
      line[k*N +: N] = (wr && wa == fa) ? blk[k*N +: N] : mem[{fa, k[1:0]}];
    end
    if (expect_fill) fill_q.push_back(line);
    fill_addr = fa;
    wb_addr   = wa;
    wb_block  = blk;
    wb_req    = wr;
    fill_req  = 1'b1;
    @(posedge clk); #1;
    fill_req = 1'b0;
    wb_req   = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL accept_busy: busy=%0b required 1", busy);
    end
  endtask

  // Wait (bounded) for done; cycle numbering: the current cycle is start_cycle.
  task automatic wait_done(input int lat, input int start_cycle, input string name);
    int cyc;
    bit found;
    cyc = start_cycle;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL %s: done never seen, required at cycle %0d", name, lat);
    end else if (cyc != lat) begin
      errors++;
      $display("[TB] FAIL %s: done at cycle %0d required %0d", name, cyc, lat);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || L2_read_request !== 1'b0 || L2_write_request !== 1'b0 ||
          fill_block !== '0 || L2_word_address !== '0 || L2_wdata !== '0) begin
        errors++;
        $display("[TB] FAIL reset_idle: busy=%0b done=%0b rd=%0b wr=%0b addr=%h fb=%h required all 0",
                 busy, done, L2_read_request, L2_write_request, L2_word_address, fill_block);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fill();
    mem[15'h0A0] = 32'h11; mem[15'h0A1] = 32'h22;
    mem[15'h0A2] = 32'h33; mem[15'h0A3] = 32'h44;
    start_fill(13'h028, 1'b0, 13'h000, '0, 1'b1);
    wait_done(6, 1, "fill_latency");
    checks++;
    if (fill_block !== 128'h00000044_00000033_00000022_00000011) begin
      errors++;
      $display("[TB] FAIL fill_value: got %h required 00000044000000330000002200000011", fill_block);
    end
    @(posedge clk); #1;
    checks++;
    if (acc_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fill_drain: pending=%0d busy=%0b required 0/0", acc_q.size(), busy);
    end
  endtask

  task automatic test_writeback();
    for (int k = 0; k < WORDS; k++) mem[15'h008 + k] = 32'h8000 + k;
    start_fill(13'h002, 1'b1, 13'h001,
               {32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001, 32'hDEAD0000}, 1'b1);
    wait_done(10, 1, "wb_latency");
    @(posedge clk); #1;
    checks++;
    if (mem[15'h005] !== 32'hDEAD0001) begin
      errors++;
      $display("[TB] FAIL wb_memory: mem[005]=%h required DEAD0001", mem[15'h005]);
    end
    checks++;
    if (acc_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL wb_drain: pending=%0d required 0", acc_q.size());
    end
  endtask

  task automatic test_last_block();
    for (int k = 0; k < WORDS; k++) begin
      mem[15'h7FFC + k] = 32'hF0000000 + k;
      mem[k]            = 32'h0BAD0000 + k;
    end
    start_fill(13'h1FFF, 1'b0, 13'h000, '0, 1'b1);
    wait_done(6, 1, "last_latency");
    checks++;
    if (fill_block[127:96] !== 32'hF0000003 || fill_block[31:0] !== 32'hF0000000) begin
      errors++;
      $display("[TB] FAIL last_block: got %h required words F0000000..F0000003", fill_block);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ignored_request();
    int d0;
    for (int k = 0; k < WORDS; k++) begin
      mem[15'h040 + k] = 32'h5500 + k;
      mem[15'h080 + k] = 32'h6600 + k;
    end
    d0 = done_count;
    start_fill(13'h010, 1'b0, 13'h000, '0, 1'b1);
    @(posedge clk); #1;
    fill_req  = 1'b1;
    wb_req    = 1'b1;
    fill_addr = 13'h020;
    wb_addr   = 13'h005;
    @(posedge clk); #1;
    fill_req = 1'b0;
    wb_req   = 1'b0;
    wait_done(6, 3, "ignored_latency");
    checks++;
    if (fill_block[31:0] !== 32'h5500) begin
      errors++;
      $display("[TB] FAIL ignored_data: word0=%h required 00005500", fill_block[31:0]);
    end
    repeat (8) begin
      @(posedge clk); #1;
    end
    checks++;
    if (done_count - d0 != 1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ignored_once: dones=%0d busy=%0b required 1/0", done_count - d0, busy);
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    for (int k = 0; k < WORDS; k++) mem[15'h0C0 + k] = 32'h7700 + k;
    start_fill(13'h030, 1'b0, 13'h000, '0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || L2_read_request !== 1'b0 || L2_write_request !== 1'b0 ||
        fill_block !== '0) begin
      errors++;
      $display("[TB] FAIL reset_abort: busy=%0b done=%0b rd=%0b wr=%0b fb=%h required all 0",
               busy, done, L2_read_request, L2_write_request, fill_block);
    end
    checks++;
    if (acc_q.size() != 1) begin
      errors++;
      $display("[TB] FAIL reset_reads: pending=%0d required 1", acc_q.size());
    end
    acc_q.delete();
    d0 = done_count;
    repeat (8) begin
      @(posedge clk); #1;
    end
    checks++;
    if (done_count != d0) begin
      errors++;
      $display("[TB] FAIL reset_no_done: dones=%0d required 0", done_count - d0);
    end
    start_fill(13'h030, 1'b0, 13'h000, '0, 1'b1);
    wait_done(6, 1, "post_reset_latency");
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < WORDS; k++) begin
      mem[15'h100 + k] = 32'h9900 + k;
      mem[15'h104 + k] = 32'hAA00 + k;
    end
    start_fill(13'h040, 1'b0, 13'h000, '0, 1'b1);
    wait_done(6, 1, "b2b_first_latency");
    fill_req  = 1'b1;
    fill_addr = 13'h041;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL no_accept_in_done: busy=%0b required 0", busy);
    end
    start_fill(13'h041, 1'b0, 13'h000, '0, 1'b1);
    wait_done(6, 1, "b2b_second_latency");
    @(posedge clk); #1;
    checks++;
    if (acc_q.size() != 0 || fill_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL b2b_drain: pending acc=%0d fill=%0d required 0/0", acc_q.size(), fill_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    reset     = 1'b1;
    fill_req  = 1'b0;
    wb_req    = 1'b0;
    fill_addr = '0;
    wb_addr   = '0;
    wb_block  = '0;
    test_reset();
    test_fill();
    test_writeback();
    test_last_block();
    test_ignored_request();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/l2_mem_block_engine.md
Name: l2_mem_block_engine

Overview:
- Memory-side transfer engine of the L2 cache controller, directly upstream of main_memory.
- Turns one block-level L2 request (optional dirty writeback, then a line fill) into sequential single-word accesses on main_memory's L2_* word port.
- Assembles the returned words into a full line for the L2 data array.
- Signals completion with a one-cycle done pulse.

Parameters:
- n, 32, data word width (matches main_memory).
- WORDS, 4, words per cache block (16-byte block); power of two, ≥2.
- ADDR_W, 15, word address width of main_memory.
- BLK_W, ADDR_W-$clog2(WORDS) = 13, block address width.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- fill_req  in  1  request a line fill from fill_addr; sampled only in IDLE.
- wb_req  in  1  write back wb_block to wb_addr before the fill; sampled only in IDLE with fill_req.
- fill_addr  in  BLK_W  block address to fetch.
- wb_addr  in  BLK_W  block address of victim.
- wb_block  in  n*WORDS  victim data; word k = bits [k*n +: n]; must be held stable while busy.
- busy  out  1  engine not in IDLE.
- done  out  1  one-cycle pulse: fill_block valid.
- fill_block  out  n*WORDS  assembled line; word k at [k*n +: n]; held until overwritten by the next fill.
- L2_word_address  out  ADDR_W  {block_addr, word_index}.
- L2_read_request  out  1  to main_memory.
- L2_write_request  out  1  to main_memory.
- L2_wdata  out  n  write data to main_memory.
- L2_rdata  in  n  read data from main_memory, valid the cycle after the read request.

Behaviour:
- Memory contract:
  - Write commits at the edge where L2_write_request = 1.
  - L2_rdata for a read issued in cycle c is sampled at the end of cycle c+1.
  - Never assert L2_read_request and L2_write_request together.
- FSM states: IDLE, WB, RD, RLAST, DONE.
- Memory-side outputs are Moore, decoded from state and word counter idx (log2 WORDS bits).
- IDLE:
  - All requests low; address and wdata driven 0.
  - On fill_req=1: latch fill_addr and wb_addr, clear idx.
  - Next state is WB if wb_req=1, else RD.
  - wb_req without fill_req is ignored.
- WB, one word per cycle for WORDS cycles:
  - L2_write_request=1, address={wb_addr_q,idx}, L2_wdata=wb_block[idx*n +: n].
  - idx increments each cycle; on idx=WORDS-1 go to RD with idx cleared.
- RD, WORDS cycles:
  - L2_read_request=1, address={fill_addr_q,idx}.
  - From the 2nd RD cycle on, capture L2_rdata into word idx-1 of the line buffer.
  - On idx=WORDS-1 go to RLAST.
- RLAST, 1 cycle:
  - No request.
  - Capture L2_rdata into word WORDS-1.
  - Go to DONE.
- DONE, 1 cycle:
  - done=1; fill_block updated from the buffer, or the buffer drives it directly.
  - Go to IDLE. A new request can be accepted in the first following IDLE cycle, never in DONE.
- busy=1 in every state except IDLE.
- Latency, from the accepting edge to done high:
  - Fill only: WORDS+2 cycles (6 for the defaults).
  - With writeback: 2*WORDS+2 cycles (10 for the defaults).
- fill_req/wb_req while busy: ignored, no queuing; the requester holds the request until done.
- idx wraps naturally at WORDS; address low bits = idx exactly, no carry into block bits.
- fill_addr/wb_addr changes after acceptance have no effect (latched copies used).
- Reset values: state IDLE, idx 0, busy 0, done 0, fill_block 0, all memory-side outputs 0.
- Reset mid-operation:
  - Abort immediately; outputs are 0 from the cycle after the reset edge.
  - A partial writeback may leave memory partly updated (accepted).
  - fill_block is cleared to 0; no done pulse.

Test Plan:
- Reset, then idle 5 cycles -> busy=0, done=0, read/write requests 0, fill_block=0 throughout.
- Preload memory words 0x0A0..0x0A3 with 0x11,0x22,0x33,0x44; fill_req=1, fill_addr=0x028 -> 4 consecutive read cycles at addresses 0x0A0..0x0A3; done exactly 6 cycles after accept; fill_block=0x00000044_00000033_00000022_00000011.
- wb_req+fill_req with wb_addr=0x001, wb_block words 0xDEAD0000..0xDEAD0003, fill_addr=0x002 -> writes to 0x004..0x007 then reads 0x008..0x00B; never both requests high; done after 10 cycles; memory[0x005]=0xDEAD0001.
- Fill of the last block fill_addr=0x1FFF -> addresses 0x7FFC..0x7FFF; no wrap into other blocks.
- Pulse fill_req again 2 cycles after accept, with a different address -> ignored; exactly one done; fill_block reflects the first address only.
- Assert reset in the 3rd RD cycle -> busy, requests and fill_block are 0 on the next cycle; no done; a subsequent fill completes normally in 6 cycles.
